// File: rtl/vga_pmod_pkg.sv
`default_nettype none
// ============================================================================
// Module : vga_pmod_pkg
// Brief  : Shared constants for the Tiny VGA PMOD output stage: Bayer matrix,
//          PMOD byte bit positions and the idle (syncs high, black) byte.
// Rev    : 1.0  initial release
// ============================================================================
package vga_pmod_pkg;

    // 4x4 ordered-dither matrix, row-major: index = {y, x}
    localparam logic [3:0] BAYER4 [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    localparam int PMOD_HS    = 7;
    localparam int PMOD_VS    = 3;
    localparam int PMOD_R_MSB = 0;
    localparam int PMOD_G_MSB = 1;
    localparam int PMOD_B_MSB = 2;
    localparam int PMOD_R_LSB = 4;
    localparam int PMOD_G_LSB = 5;
    localparam int PMOD_B_LSB = 6;

    localparam logic [7:0] PMOD_IDLE = 8'h88;

    function automatic logic [3:0] bayer_threshold(input logic [1:0] y, input logic [1:0] x);
        return BAYER4[{y, x}];
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pmod_out_if.sv
`default_nettype none
// ============================================================================
// Module : vga_pmod_out_if
// Brief  : Renderer-to-PMOD bundle: wide RGB, syncs, position, controls and
//          the packed PMOD byte / frame counter coming back.
// Rev    : 1.0  initial release
// ============================================================================
interface vga_pmod_out_if #(
    parameter int IN_BPC     = 6,
    parameter int FRAME_BITS = 2
);
    logic [IN_BPC-1:0]     i_r;
    logic [IN_BPC-1:0]     i_g;
    logic [IN_BPC-1:0]     i_b;
    logic                  i_hsync_n;
    logic                  i_vsync_n;
    logic                  i_blank;
    logic [9:0]            i_hpos;
    logic [9:0]            i_vpos;
    logic                  i_dither_en;
    logic                  i_reg;
    logic                  i_pattern_en;
    logic [7:0]            o_pmod;
    logic [FRAME_BITS-1:0] o_frame;

    modport master (
        output i_r, i_g, i_b, i_hsync_n, i_vsync_n, i_blank,
        output i_hpos, i_vpos, i_dither_en, i_reg, i_pattern_en,
        input  o_pmod, o_frame
    );

    modport slave (
        input  i_r, i_g, i_b, i_hsync_n, i_vsync_n, i_blank,
        input  i_hpos, i_vpos, i_dither_en, i_reg, i_pattern_en,
        output o_pmod, o_frame
    );
endinterface
`default_nettype wire

// File: rtl/vga_dither_quant.sv
`default_nettype none
// ============================================================================
// Module : vga_dither_quant
// Brief  : One colour channel, IN_BPC bits -> 2 bits, with optional ordered
//          dither against a 4-bit threshold. Purely combinational.
// Rev    : 1.0  initial release
// ============================================================================
module vga_dither_quant
    import vga_pmod_pkg::*;
#(
    parameter int IN_BPC = 6
) (
    input  logic [IN_BPC-1:0] c,
    input  logic [3:0]        t,
    input  logic              en,
    output logic [1:0]        q
);
    logic [1:0] base;
    logic [3:0] e;

    assign base = c[IN_BPC-1 -: 2];

    // Residual is left-aligned to 4 bits so it compares directly with t
    generate
        if (IN_BPC == 2) begin : g_no_res
            assign e = 4'd0;
        end else if (IN_BPC >= 6) begin : g_trunc_res
            assign e = c[IN_BPC-3 -: 4];
            if (IN_BPC > 6) begin : g_drop_lsbs
                logic unused_res_lsbs;
                assign unused_res_lsbs = ^c[IN_BPC-7:0];
            end
        end else begin : g_pad_res
            assign e = {c[IN_BPC-3:0], {(6-IN_BPC){1'b0}}};
        end
    endgenerate

    always_comb begin
        q = base;
        if (en && (e > t) && (base != 2'd3)) begin
            q = base + 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_pmod_out.sv
`default_nettype none
// ============================================================================
// Module : vga_pmod_out
// Brief  : Dithered 2-bit-per-channel VGA output stage for the Tiny VGA PMOD,
//          with blanking, matched delay pipeline and runtime bypass.
//          Optional colour-bar generator: define VGA_PMOD_OUT_PATTERN_EN.
// Rev    : 1.0  initial release
// ============================================================================
module vga_pmod_out
    import vga_pmod_pkg::*;
#(
    parameter int IN_BPC      = 6,
    parameter int PIPE_STAGES = 1,
    parameter int FRAME_BITS  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_pmod_out_if.slave    bus
);
    logic [FRAME_BITS-1:0] frame;
    logic                  prev_vsync_n;
    logic [IN_BPC-1:0]     src_r;
    logic [IN_BPC-1:0]     src_g;
    logic [IN_BPC-1:0]     src_b;
    logic [1:0]            dither_x;
    logic [3:0]            threshold;
    logic [1:0]            q_r;
    logic [1:0]            q_g;
    logic [1:0]            q_b;
    logic [7:0]            stage0;
    logic [7:0]            delayed;
    logic                  unused_pos;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame        <= '0;
            prev_vsync_n <= 1'b1;
        end else begin
            prev_vsync_n <= bus.i_vsync_n;
            if (prev_vsync_n && !bus.i_vsync_n) begin
                frame <= frame + 1'b1;
            end
        end
    end

    assign bus.o_frame = frame;

`ifdef VGA_PMOD_OUT_PATTERN_EN
    logic [2:0] bar;
    assign bar   = bus.i_hpos[9:7];
    assign src_r = bus.i_pattern_en ? {IN_BPC{bar[0]}} : bus.i_r;
    assign src_g = bus.i_pattern_en ? {IN_BPC{bar[1]}} : bus.i_g;
    assign src_b = bus.i_pattern_en ? {IN_BPC{bar[2]}} : bus.i_b;
`else
    logic unused_pattern_en;
    assign unused_pattern_en = bus.i_pattern_en;
    assign src_r = bus.i_r;
    assign src_g = bus.i_g;
    assign src_b = bus.i_b;
`endif

    assign unused_pos = ^{bus.i_hpos[9:2], bus.i_vpos[9:2]};

    // Frame count slides the matrix horizontally so the pattern crawls over time
    assign dither_x  = bus.i_hpos[1:0] + frame[1:0];
    assign threshold = bayer_threshold(bus.i_vpos[1:0], dither_x);

    vga_dither_quant #(.IN_BPC(IN_BPC)) u_quant_r (
        .c  (src_r),
        .t  (threshold),
        .en (bus.i_dither_en),
        .q  (q_r)
    );

    vga_dither_quant #(.IN_BPC(IN_BPC)) u_quant_g (
        .c  (src_g),
        .t  (threshold),
        .en (bus.i_dither_en),
        .q  (q_g)
    );

    vga_dither_quant #(.IN_BPC(IN_BPC)) u_quant_b (
        .c  (src_b),
        .t  (threshold),
        .en (bus.i_dither_en),
        .q  (q_b)
    );

    always_comb begin
        stage0          = 8'h00;
        stage0[PMOD_HS] = bus.i_hsync_n;
        stage0[PMOD_VS] = bus.i_vsync_n;
        if (!bus.i_blank) begin
            stage0[PMOD_R_MSB] = q_r[1];
            stage0[PMOD_G_MSB] = q_g[1];
            stage0[PMOD_B_MSB] = q_b[1];
            stage0[PMOD_R_LSB] = q_r[0];
            stage0[PMOD_G_LSB] = q_g[0];
            stage0[PMOD_B_LSB] = q_b[0];
        end
    end

    // Whole byte travels together, so syncs and colour cannot skew
    generate
        if (PIPE_STAGES > 0) begin : g_pipe
            logic [7:0] pipe [PIPE_STAGES];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIPE_STAGES; i++) begin
                        pipe[i] <= PMOD_IDLE;
                    end
                end else begin
                    pipe[0] <= stage0;
                    for (int i = 1; i < PIPE_STAGES; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign delayed = pipe[PIPE_STAGES-1];
        end else begin : g_no_pipe
            assign delayed = stage0;
        end
    endgenerate

    assign bus.o_pmod = bus.i_reg ? delayed : stage0;

endmodule
`default_nettype wire

// File: tb/tb_vga_pmod_out.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_pmod_out
// Brief  : Self-checking bench for vga_pmod_out (IN_BPC=6, PIPE_STAGES=2).
// Rev    : 1.0  initial release
// ============================================================================
module tb_vga_pmod_out;
    localparam int IN_BPC = 6;
    localparam int PIPE   = 2;
    localparam int FB     = 2;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    vga_pmod_out_if #(.IN_BPC(IN_BPC), .FRAME_BITS(FB)) bus ();

    vga_pmod_out #(.IN_BPC(IN_BPC), .PIPE_STAGES(PIPE), .FRAME_BITS(FB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int bay [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

    function automatic int quant(input int c, input int t, input bit en);
        int q, res, e;
        q   = c >> (IN_BPC - 2);
        res = c % (1 << (IN_BPC - 2));
        e   = (IN_BPC == 2) ? 0 : (res * 16) >> (IN_BPC - 2);
        if (en && e > t && q < 3) q = q + 1;
        return q;
    endfunction

    // Reference for the unregistered byte, from the current inputs and a frame count
    function automatic logic [7:0] model_byte(input int frame);
        int r, g, b, k, x, y, t, qr, qg, qb;
        logic [7:0] v;
        r = int'(bus.i_r); g = int'(bus.i_g); b = int'(bus.i_b);
`ifdef VGA_PMOD_OUT_PATTERN_EN
        if (bus.i_pattern_en) begin
            k = int'(bus.i_hpos) / 128;
            r = (k % 2 == 1)       ? (1 << IN_BPC) - 1 : 0;
            g = ((k / 2) % 2 == 1) ? (1 << IN_BPC) - 1 : 0;
            b = ((k / 4) % 2 == 1) ? (1 << IN_BPC) - 1 : 0;
        end
`endif
        x  = (int'(bus.i_hpos) % 4 + frame) % 4;
        y  = int'(bus.i_vpos) % 4;
        t  = bay[y][x];
        qr = quant(r, t, bus.i_dither_en);
        qg = quant(g, t, bus.i_dither_en);
        qb = quant(b, t, bus.i_dither_en);
        if (bus.i_blank) begin qr = 0; qg = 0; qb = 0; end
        v    = 8'h00;
        v[7] = bus.i_hsync_n;
        v[6] = qb[0]; v[5] = qg[0]; v[4] = qr[0];
        v[3] = bus.i_vsync_n;
        v[2] = qb[1]; v[1] = qg[1]; v[0] = qr[1];
        return v;
    endfunction

    int         mframe;
    bit         mprev;
    logic [7:0] hist [$];

    initial begin
        mframe = 0;
        mprev  = 1'b1;
        for (int i = 0; i < PIPE; i++) hist.push_back(8'h88);
    end

    // Registered path = what the bypass showed PIPE cycles ago; reset fills with idle
    always @(posedge clk) begin
        if (!rst_n) begin
            mframe = 0;
            mprev  = 1'b1;
            hist.delete();
            for (int i = 0; i < PIPE; i++) hist.push_back(8'h88);
        end else begin
            hist.push_front(model_byte(mframe));
            void'(hist.pop_back());
            if (mprev && !bus.i_vsync_n) mframe = (mframe + 1) % (1 << FB);
            mprev = bus.i_vsync_n;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_px(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b,
                          input logic [9:0] h, input logic [9:0] v, input logic blank,
                          input logic den, input logic hs, input logic vs);
        bus.i_r = r; bus.i_g = g; bus.i_b = b;
        bus.i_hpos = h; bus.i_vpos = v;
        bus.i_blank = blank; bus.i_dither_en = den;
        bus.i_hsync_n = hs; bus.i_vsync_n = vs;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic [5:0] r, g, b;
        logic [9:0] h, v;
        logic       blank, den, hs, vs;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [9];
    int   n3, n2;

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.i_reg = 1'b1;
        bus.i_pattern_en = 1'b0;
        set_px(6'h00, 6'h00, 6'h00, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Reset: registered path idles, bypass still follows inputs
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pmod", 32'(bus.o_pmod), 32'h88);
        chk("reset_frame", 32'(bus.o_frame), 32'h0);
        set_px(6'h3F, 6'h3F, 6'h3F, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        bus.i_reg = 1'b0;
        #1;
        chk("reset_bypass", 32'(bus.o_pmod), 32'hFF);
        bus.i_reg = 1'b1;
        #1;
        chk("reset_reg_hold", 32'(bus.o_pmod), 32'h88);
        rst_n = 1'b1;

        vecs[0] = '{6'h28, 6'h00, 6'h00, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h99};
        vecs[1] = '{6'h28, 6'h00, 6'h00, 10'd1, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h89};
        vecs[2] = '{6'h28, 6'h00, 6'h00, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h89};
        vecs[3] = '{6'h3F, 6'h3F, 6'h3F, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF};
        vecs[4] = '{6'h3F, 6'h3F, 6'h3F, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h88};
        vecs[5] = '{6'h3F, 6'h3F, 6'h3F, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h08};
        vecs[6] = '{6'h00, 6'h10, 6'h00, 10'd2, 10'd1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA8};
        vecs[7] = '{6'h00, 6'h00, 6'h1F, 10'd3, 10'd3, 1'b0, 1'b1, 1'b1, 1'b1, 8'h8C};
        vecs[8] = '{6'h3F, 6'h00, 6'h00, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h91};

        bus.i_reg = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            set_px(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].h, vecs[i].v,
                   vecs[i].blank, vecs[i].den, vecs[i].hs, vecs[i].vs);
            #1;
            chk($sformatf("vec%0d", i), 32'(bus.o_pmod), 32'(vecs[i].exp));
        end

        // 4x4 sweep at frame 0: half the block rounds up, truncation never does
        set_px(6'h00, 6'h00, 6'h00, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        do_reset();
        n3 = 0;
        n2 = 0;
        for (int v = 0; v < 4; v++) begin
            for (int h = 0; h < 4; h++) begin
                @(posedge clk);
                #1;
                set_px(6'h28, 6'h00, 6'h00, 10'(h), 10'(v), 1'b0, 1'b1, 1'b1, 1'b1);
                #1;
                if (bus.o_pmod[0] && bus.o_pmod[4]) n3++;
            end
        end
        chk("dither_count3", 32'(n3), 32'd8);
        for (int v = 0; v < 4; v++) begin
            for (int h = 0; h < 4; h++) begin
                @(posedge clk);
                #1;
                set_px(6'h28, 6'h00, 6'h00, 10'(h), 10'(v), 1'b0, 1'b0, 1'b1, 1'b1);
                #1;
                if (bus.o_pmod[0] && !bus.o_pmod[4]) n2++;
            end
        end
        chk("trunc_count2", 32'(n2), 32'd16);

        // Three falling vsync edges, the last held low
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 bus.i_vsync_n = 1'b0;
            if (i < 2) begin @(posedge clk); #1 bus.i_vsync_n = 1'b1; end
        end
        @(posedge clk); #1;
        chk("frame_three", 32'(bus.o_frame), 32'd3);
        repeat (4) @(posedge clk);
        #1;
        chk("frame_hold_low", 32'(bus.o_frame), 32'd3);
        set_px(6'h28, 6'h00, 6'h00, 10'd1, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        chk("temporal_offset", 32'(bus.o_pmod), 32'h91);

        // Matched two-cycle delay of sync and colour
        set_px(6'h00, 6'h00, 6'h00, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        bus.i_reg = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        set_px(6'h3F, 6'h00, 6'h00, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        bus.i_reg = 1'b0;
        #1 chk("pipe_bypass_now", 32'(bus.o_pmod), 32'h19);
        bus.i_reg = 1'b1;
        #1 chk("pipe_reg_d0", 32'(bus.o_pmod), 32'h88);
        @(posedge clk); #1;
        set_px(6'h00, 6'h00, 6'h00, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        #1 chk("pipe_reg_d1", 32'(bus.o_pmod), 32'h88);
        @(posedge clk); #2;
        chk("pipe_reg_d2", 32'(bus.o_pmod), 32'h19);
        @(posedge clk); #2;
        chk("pipe_reg_d3", 32'(bus.o_pmod), 32'h88);

        // Colour bars: bar 5 = magenta when the generator is built in
        bus.i_reg = 1'b0;
        bus.i_pattern_en = 1'b1;
        set_px(6'h00, 6'h00, 6'h00, 10'd640, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        #1;
`ifdef VGA_PMOD_OUT_PATTERN_EN
        chk("pattern_bar5", 32'(bus.o_pmod), 32'hDD);
`else
        chk("pattern_ignored", 32'(bus.o_pmod), 32'h88);
`endif
        bus.i_blank = 1'b1;
        #1 chk("pattern_blank", 32'(bus.o_pmod), 32'h88);
        bus.i_pattern_en = 1'b0;

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            rst_n            = ($urandom_range(0, 39) != 0);
            bus.i_r          = 6'($urandom);
            bus.i_g          = 6'($urandom);
            bus.i_b          = 6'($urandom);
            bus.i_hpos       = 10'($urandom);
            bus.i_vpos       = 10'($urandom);
            bus.i_hsync_n    = ($urandom_range(0, 3) != 0);
            bus.i_vsync_n    = ($urandom_range(0, 2) != 0);
            bus.i_blank      = ($urandom_range(0, 4) == 0);
            bus.i_dither_en  = 1'($urandom);
            bus.i_reg        = 1'($urandom);
            bus.i_pattern_en = ($urandom_range(0, 5) == 0);
            #1;
            chk("rand_pmod", 32'(bus.o_pmod),
                32'(bus.i_reg ? hist[PIPE-1] : model_byte(mframe)));
            chk("rand_frame", 32'(bus.o_frame), 32'(mframe));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
